sfifo_pkt: RTL and testbench

SFIFO_PKT -- requirements
Module: sfifo_pkt

---
 rtl/sfifo_pkt_if.sv | 29 ++
 rtl/sfifo_pkt.sv | 113 +++++++++++
 tb/tb_sfifo_pkt.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sfifo_pkt_if.sv
// Producer/consumer bundle for sfifo_pkt; the producer side owns the write and ready inputs,
// the FIFO side owns status, head data and valid.
interface sfifo_pkt_if #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
);
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              i_last;
  logic              i_abort;
  logic              o_full;
  logic [LGFLEN:0]   o_fill;
  logic [LGFLEN:0]   o_pkts;
  logic              o_overflow;
  logic              o_valid;
  logic              i_ready;
  logic [BW-1:0]     o_data;
  logic              o_last;

  modport master (
    output i_wr, i_data, i_last, i_abort, i_ready,
    input  o_full, o_fill, o_pkts, o_overflow, o_valid, o_data, o_last
  );

  modport slave (
    input  i_wr, i_data, i_last, i_abort, i_ready,
    output o_full, o_fill, o_pkts, o_overflow, o_valid, o_data, o_last
  );
endinterface

// File: rtl/sfifo_pkt.sv
// Packet FIFO: head word is a zero-latency read, a committed write is visible to the reader
// next cycle; o_valid is the reader handshake and a write while full is refused (dropping the packet).
module sfifo_pkt #(
  parameter int BW           = 8,
  parameter int LGFLEN       = 4,
  parameter int OPT_PKT_MODE = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  sfifo_pkt_if.slave bus
);
  localparam int              FLEN   = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FLEN_W = (LGFLEN+1)'(FLEN);
  localparam logic [LGFLEN:0] ONE    = (LGFLEN+1)'(1);
  localparam bit              PKT    = (OPT_PKT_MODE != 0);

  logic [BW:0]     mem_q [FLEN];
  logic [LGFLEN:0] wr_addr_q, wr_addr_d;
  logic [LGFLEN:0] wr_commit_q, wr_commit_d;
  logic [LGFLEN:0] rd_addr_q, rd_addr_d;
  logic [LGFLEN:0] fill_q, fill_d;
  logic [LGFLEN:0] pkts_q, pkts_d;
  logic            drop_q, drop_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            valid;
  logic            w_wr, w_rd, pkt_inc, pkt_dec;
  logic [BW:0]     head;

  assign head  = mem_q[rd_addr_q[LGFLEN-1:0]];
  assign valid = (wr_commit_q != rd_addr_q);

  assign bus.o_valid    = valid;
  assign bus.o_data     = head[BW-1:0];
  assign bus.o_last     = head[BW];
  assign bus.o_fill     = fill_q;
  assign bus.o_full     = full_q;
  assign bus.o_pkts     = pkts_q;
  assign bus.o_overflow = ovf_q;

  always_comb begin
    w_wr        = bus.i_wr && !full_q && !drop_q && !(PKT && bus.i_abort);
    w_rd        = valid && bus.i_ready;
    wr_addr_d   = w_wr ? wr_addr_q + ONE : wr_addr_q;
    wr_commit_d = wr_commit_q;
    rd_addr_d   = w_rd ? rd_addr_q + ONE : rd_addr_q;
    drop_d      = drop_q;
    ovf_d       = 1'b0;
    pkt_inc     = 1'b0;
    pkt_dec     = w_rd && head[BW];

    if (PKT) begin
      // Rollback cases all rewind the tentative pointer to the last commit point.
      if (bus.i_abort) begin
        wr_addr_d = wr_commit_q;
        drop_d    = 1'b0;
      end else if (bus.i_wr && full_q && !drop_q) begin
        wr_addr_d = wr_commit_q;
        ovf_d     = 1'b1;
        drop_d    = !bus.i_last;
      end else if (bus.i_wr && drop_q) begin
        if (bus.i_last)
          drop_d = 1'b0;
      end else if (w_wr && bus.i_last) begin
        wr_commit_d = wr_addr_q + ONE;
        pkt_inc     = 1'b1;
      end
    end else begin
      ovf_d = bus.i_wr && full_q;
      if (w_wr) begin
        wr_commit_d = wr_addr_q + ONE;
        pkt_inc     = bus.i_last;
      end
    end

    pkts_d = pkts_q;
    if (pkt_inc && !pkt_dec)
      pkts_d = pkts_q + ONE;
    else if (!pkt_inc && pkt_dec)
      pkts_d = pkts_q - ONE;

    fill_d = wr_addr_d - rd_addr_d;
    full_d = (fill_d == FLEN_W);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_addr_q   <= '0;
      wr_commit_q <= '0;
      rd_addr_q   <= '0;
      fill_q      <= '0;
      pkts_q      <= '0;
      drop_q      <= 1'b0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      wr_commit_q <= wr_commit_d;
      rd_addr_q   <= rd_addr_d;
      fill_q      <= fill_d;
      pkts_q      <= pkts_d;
      drop_q      <= drop_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage is not reset; o_valid gates every read.
  always_ff @(posedge i_clk) begin
    if (w_wr)
      mem_q[wr_addr_q[LGFLEN-1:0]] <= {bus.i_last, bus.i_data};
  end
endmodule

// File: tb/tb_sfifo_pkt.sv
// Directed bench: packet-mode FIFO (a) and immediate-commit FIFO (b), both 4 deep, 8 bits wide.
module tb_sfifo_pkt;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  sfifo_pkt_if #(.BW(8), .LGFLEN(2)) a_if ();
  sfifo_pkt_if #(.BW(8), .LGFLEN(2)) b_if ();

  sfifo_pkt #(.BW(8), .LGFLEN(2), .OPT_PKT_MODE(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(a_if)
  );
  sfifo_pkt #(.BW(8), .LGFLEN(2), .OPT_PKT_MODE(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_st(input string tag, input logic v, input logic [2:0] fill, input logic [2:0] pkts);
    check({tag, ".valid"}, 16'(a_if.o_valid), 16'(v));
    check({tag, ".fill"},  16'(a_if.o_fill),  16'(fill));
    check({tag, ".pkts"},  16'(a_if.o_pkts),  16'(pkts));
  endtask

  task automatic a_drv(input logic wr, input logic [7:0] d, input logic last, input logic abort);
    a_if.i_wr = wr; a_if.i_data = d; a_if.i_last = last; a_if.i_abort = abort;
  endtask

  task automatic b_drv(input logic wr, input logic [7:0] d, input logic last, input logic abort);
    b_if.i_wr = wr; b_if.i_data = d; b_if.i_last = last; b_if.i_abort = abort;
  endtask

  initial begin
    logic [7:0] seq [4];
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    a_drv(0, 8'h00, 0, 0); a_if.i_ready = 1'b0;
    b_drv(0, 8'h00, 0, 0); b_if.i_ready = 1'b0;
    #2;
    a_st("rst_a", 0, 0, 0);
    check("rst_a.full", 16'(a_if.o_full), 16'h0);
    check("rst_a.ovf", 16'(a_if.o_overflow), 16'h0);
    check("rst_b.valid", 16'(b_if.o_valid), 16'h0);
    check("rst_b.fill", 16'(b_if.o_fill), 16'h0);
    #10 rst = 1'b0;
    tick();

    // Commit: nothing visible until the last word is accepted.
    a_drv(1, 8'h11, 0, 0); tick(); a_st("cm1", 0, 1, 0);
    a_drv(1, 8'h22, 0, 0); tick(); a_st("cm2", 0, 2, 0);
    a_drv(1, 8'h33, 1, 0); tick(); a_st("cm3", 1, 3, 1);
    a_drv(0, 8'h00, 0, 0);
    a_if.i_ready = 1'b1;
    check("cm.rd0", {a_if.o_last, 7'd0, a_if.o_data}, 16'h0011); tick();
    check("cm.rd1", {a_if.o_last, 7'd0, a_if.o_data}, 16'h0022); tick();
    check("cm.rd2", {a_if.o_last, 7'd0, a_if.o_data}, 16'h8033); tick();
    a_if.i_ready = 1'b0;
    a_st("cm.empty", 0, 0, 0);

    // Abort with a same-cycle write.
    a_drv(1, 8'hA0, 0, 0); tick();
    a_drv(1, 8'hA1, 0, 0); tick(); a_st("ab2", 0, 2, 0);
    a_drv(1, 8'hA2, 0, 1); tick(); a_st("ab3", 0, 0, 0);
    a_drv(1, 8'h5A, 1, 0); tick(); a_st("ab4", 1, 1, 1);
    a_drv(0, 8'h00, 0, 0);
    check("ab.head", 16'(a_if.o_data), 16'h005A);
    a_if.i_ready = 1'b1; tick(); a_if.i_ready = 1'b0;
    a_st("ab.empty", 0, 0, 0);

    // Overflow drops the packet through its last word.
    for (int i = 1; i <= 4; i++) begin
      a_drv(1, 8'(i), 0, 0); tick();
    end
    check("of.full", 16'(a_if.o_full), 16'h1);
    check("of.ovf0", 16'(a_if.o_overflow), 16'h0);
    a_drv(1, 8'h05, 0, 0); tick();
    check("of.ovf1", 16'(a_if.o_overflow), 16'h1);
    a_st("of.rollback", 0, 0, 0);
    a_drv(1, 8'h06, 0, 0); tick();
    check("of.ovf2", 16'(a_if.o_overflow), 16'h0);
    a_st("of.drop1", 0, 0, 0);
    a_drv(1, 8'h07, 1, 0); tick(); a_st("of.drop2", 0, 0, 0);
    a_drv(1, 8'h55, 1, 0); tick(); a_st("of.next", 1, 1, 1);
    a_drv(0, 8'h00, 0, 0);
    check("of.head", {a_if.o_last, 7'd0, a_if.o_data}, 16'h8055);
    a_if.i_ready = 1'b1; tick(); a_if.i_ready = 1'b0;
    a_st("of.empty", 0, 0, 0);

    // Full with a simultaneous read still refuses the write.
    for (int i = 0; i < 4; i++) begin
      a_drv(1, 8'hC0 + 8'(i), 1, 0); tick();
    end
    a_st("fr.full", 1, 4, 4);
    check("fr.fullflag", 16'(a_if.o_full), 16'h1);
    a_drv(1, 8'hEE, 1, 0); a_if.i_ready = 1'b1; tick();
    check("fr.ovf", 16'(a_if.o_overflow), 16'h1);
    a_st("fr.after", 1, 3, 3);
    check("fr.head", 16'(a_if.o_data), 16'h00C1);
    a_drv(0, 8'h00, 0, 0);
    tick(); tick(); tick();
    a_if.i_ready = 1'b0;
    a_st("fr.drain", 0, 0, 0);
    check("fr.ovf_low", 16'(a_if.o_overflow), 16'h0);

    // Async reset between edges with committed and uncommitted data.
    a_drv(1, 8'h90, 1, 0); tick();
    a_drv(1, 8'h91, 0, 0); tick();
    a_drv(1, 8'h92, 0, 0); tick();
    a_drv(0, 8'h00, 0, 0);
    a_st("ar.pre", 1, 3, 1);
    #2 rst = 1'b1;
    #1;
    a_st("ar.in", 0, 0, 0);
    check("ar.full", 16'(a_if.o_full), 16'h0);
    check("ar.ovf", 16'(a_if.o_overflow), 16'h0);
    #2 rst = 1'b0;
    tick();
    a_drv(1, 8'h77, 1, 0); tick();
    a_drv(0, 8'h00, 0, 0);
    a_st("ar.post", 1, 1, 1);
    check("ar.head", {a_if.o_last, 7'd0, a_if.o_data}, 16'h8077);
    a_if.i_ready = 1'b1; tick(); a_if.i_ready = 1'b0;
    a_st("ar.empty", 0, 0, 0);

    // Immediate-commit mode.
    b_drv(1, 8'h10, 0, 0); tick();
    check("nb.valid", 16'(b_if.o_valid), 16'h1);
    check("nb.fill1", 16'(b_if.o_fill), 16'h1);
    b_drv(1, 8'h20, 0, 1); tick();
    check("nb.abort_fill", 16'(b_if.o_fill), 16'h2);
    check("nb.abort_valid", 16'(b_if.o_valid), 16'h1);
    b_drv(0, 8'h00, 0, 0);
    b_if.i_ready = 1'b1;
    check("nb.rd0", 16'(b_if.o_data), 16'h0010); tick();
    check("nb.rd1", 16'(b_if.o_data), 16'h0020); tick();
    b_if.i_ready = 1'b0;
    check("nb.empty", 16'(b_if.o_valid), 16'h0);

    seq[0] = 8'h31; seq[1] = 8'h32; seq[2] = 8'h33; seq[3] = 8'h34;
    for (int i = 0; i < 4; i++) begin
      b_drv(1, seq[i], (i == 3), 0); tick();
      check("nb.ovf_quiet", 16'(b_if.o_overflow), 16'h0);
    end
    check("nb.pkts", 16'(b_if.o_pkts), 16'h1);
    b_drv(1, 8'h35, 0, 0); tick();
    check("nb.ovf", 16'(b_if.o_overflow), 16'h1);
    check("nb.fill4", 16'(b_if.o_fill), 16'h4);
    check("nb.full", 16'(b_if.o_full), 16'h1);
    b_drv(0, 8'h00, 0, 0); tick();
    check("nb.ovf_pulse", 16'(b_if.o_overflow), 16'h0);
    b_if.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("nb.order", 16'(b_if.o_data), 16'(seq[i]));
      tick();
    end
    b_if.i_ready = 1'b0;
    check("nb.end_fill", 16'(b_if.o_fill), 16'h0);
    check("nb.end_pkts", 16'(b_if.o_pkts), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
